// File: rtl/mul_div_unit_pkg.sv
// Shared MDU definitions: operation codes for the multiply/divide unit and its FSM state encodings.
package mul_div_unit_pkg;

    typedef enum logic [3:0] {
        MDU_OP_MULT  = 4'd0,
        MDU_OP_MULTU = 4'd1,
        MDU_OP_DIV   = 4'd2,
        MDU_OP_DIVU  = 4'd3,
        MDU_OP_MTHI  = 4'd4,
        MDU_OP_MTLO  = 4'd5,
        MDU_OP_MADD  = 4'd6,
        MDU_OP_MADDU = 4'd7,
        MDU_OP_MSUB  = 4'd8,
        MDU_OP_MSUBU = 4'd9
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_CALC = 2'd1,
        MDU_ST_FIX  = 2'd2,
        MDU_ST_DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_iter_step.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring-divide step on {acc_hi,acc_lo}.
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] shl_rem;
    logic           rem_ge;

    always_comb begin
        add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        shl_rem = {acc_hi, acc_lo[WIDTH-1]};
        rem_ge  = shl_rem >= {1'b0, opnd};
        nxt_hi  = '0;
        nxt_lo  = '0;
        if (is_div) begin
            // The remainder stays below the divisor, so the difference fits in WIDTH bits.
            nxt_hi = rem_ge ? WIDTH'(shl_rem - {1'b0, opnd}) : shl_rem[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], rem_ge};
        end else begin
            nxt_hi = add_sum[WIDTH:1];
            nxt_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO. Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate ops.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src0,
    input  logic [WIDTH-1:0] src1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    import mul_div_unit_pkg::*;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    mdu_state_e state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             neg_a, neg_b, div_q;
    logic             is_mul_op, is_div_op, signed_op, a_neg, b_neg, div_zero_req, accept;
    logic signed [2*WIDTH-1:0] prod_s, fix_res;
`ifdef MDU_MADD_EN
    logic             acc_add_q, acc_sub_q;
`endif

    always_comb begin
        is_mul_op = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
        is_div_op = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
        signed_op = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
`ifdef MDU_MADD_EN
        is_mul_op = is_mul_op || (op == MDU_OP_MADD) || (op == MDU_OP_MADDU) ||
                    (op == MDU_OP_MSUB) || (op == MDU_OP_MSUBU);
        signed_op = signed_op || (op == MDU_OP_MADD) || (op == MDU_OP_MSUB);
`endif
        a_neg        = signed_op & src0[WIDTH-1];
        b_neg        = signed_op & src1[WIDTH-1];
        abs_a        = neg_if(src0, a_neg);
        abs_b        = neg_if(src1, b_neg);
        div_zero_req = is_div_op && (src1 == '0);
        accept       = (state == MDU_ST_IDLE) && start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MDU_ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            MDU_ST_IDLE: begin
                if (start)
                    state_nxt = (is_mul_op || (is_div_op && !div_zero_req)) ? MDU_ST_CALC : MDU_ST_DONE;
            end
            MDU_ST_CALC: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) state_nxt = MDU_ST_FIX;
            end
            MDU_ST_FIX: begin
                busy      = 1'b1;
                state_nxt = MDU_ST_DONE;
            end
            MDU_ST_DONE: begin
                done      = 1'b1;
                state_nxt = MDU_ST_IDLE;
            end
            default: state_nxt = MDU_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (accept && state_nxt == MDU_ST_CALC)
            cnt <= CNT_W'(WIDTH);
        else if (state == MDU_ST_CALC)
            cnt <= cnt - CNT_W'(1);
    end

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div (div_q),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .opnd   (opnd),
        .nxt_hi (step_hi),
        .nxt_lo (step_lo)
    );

    // Iteration registers work on magnitudes; signs are reapplied in FIX.
    always_ff @(posedge clk) begin
        if (accept) begin
            neg_a  <= a_neg;
            neg_b  <= b_neg;
            div_q  <= is_div_op;
            acc_hi <= '0;
            acc_lo <= is_div_op ? abs_a : abs_b;
            opnd   <= is_div_op ? abs_b : abs_a;
`ifdef MDU_MADD_EN
            acc_add_q <= (op == MDU_OP_MADD) || (op == MDU_OP_MADDU);
            acc_sub_q <= (op == MDU_OP_MSUB) || (op == MDU_OP_MSUBU);
`endif
        end else if (state == MDU_ST_CALC) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

    always_comb begin
        prod_s  = neg_if2({acc_hi, acc_lo}, neg_a ^ neg_b);
        fix_res = prod_s;
`ifdef MDU_MADD_EN
        if (acc_add_q)      fix_res = {hi, lo} + prod_s;
        else if (acc_sub_q) fix_res = {hi, lo} - prod_s;
`endif
        // Quotient takes the sign product, remainder follows the dividend.
        if (div_q) fix_res = {neg_if(acc_hi, neg_a), neg_if(acc_lo, neg_a ^ neg_b)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            div_by_zero <= div_zero_req;
            if (div_zero_req) begin
                hi <= src0;
                lo <= '1;
            end else if (op == MDU_OP_MTHI) begin
                hi <= src0;
            end else if (op == MDU_OP_MTLO) begin
                lo <= src0;
            end
        end else if (state == MDU_ST_FIX) begin
            hi <= fix_res[2*WIDTH-1:WIDTH];
            lo <= fix_res[WIDTH-1:0];
        end
    end

endmodule
